ins_fetch_pc: RTL and testbench

//  Program-counter owner and instruction-fetch sequencer; consumer side of the PC-write interface.

---
 rtl/ins_fetch_pc.sv | 129 ++++++++++++
 tb/tb_ins_fetch_pc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_pc.sv
// ins_fetch_pc
//   Owns the architectural program counter and sequences instruction fetch.
//   Each instruction is read from instruction memory over a req/ack handshake,
//   then held with its PC for decode/execute over a valid/ready handshake.
//   Redirects from the branch/jump execute units (reg_pc_w_op/reg_pc_w_val)
//   always take priority over the sequential PC + PC_STEP advance and over a
//   memory ack arriving in the same cycle.
//
// Parameters
//   RESET_VEC     PC loaded on reset; first fetch address
//   PC_STEP       sequential PC increment
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   reg_pc_w_op   in   redirect request (1 = load reg_pc_w_val)
//   reg_pc_w_val  in   redirect target
//   mem_req       out  instruction-memory read request
//   mem_addr      out  read address (current PC)
//   mem_ack       in   read done, mem_rdata valid this cycle
//   mem_rdata     in   instruction word
//   ins_valid     out  ins_data/ins_pc valid to decode
//   ins_ready     in   decode/execute consumes the instruction this cycle
//   ins_data      out  held instruction word
//   ins_pc        out  PC of ins_data
//   fetch_fault   out  misaligned redirect trap
//
// Configuration
//   INS_FETCH_ALIGN_CHK_EN  when defined, a redirect whose target has
//   reg_pc_w_val[1:0] != 0 is refused: PC is not loaded, fetch_fault is set
//   and the block parks in S_FAULT until reset. When undefined, fetch_fault
//   is tied low and targets are fetched exactly as given.

module ins_fetch_pc #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_pc_w_op,
  input  logic [31:0] reg_pc_w_val,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic        fetch_fault
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
`ifdef INS_FETCH_ALIGN_CHK_EN
  localparam logic [1:0] S_FAULT = 2'd3;
`endif

  logic [1:0]  state;
  logic [31:0] pc;
  logic        redirect;

  // Redirects are only honoured once fetching has started.
  assign redirect = reg_pc_w_op && ((state == S_REQ) || (state == S_VALID));

  assign mem_req   = (state == S_REQ);
  assign ins_valid = (state == S_VALID);
  assign mem_addr  = pc;

`ifdef INS_FETCH_ALIGN_CHK_EN
  logic fault_q;
  logic misaligned;

  assign misaligned  = |reg_pc_w_val[1:0];
  assign fetch_fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect && misaligned) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_VEC;
      ins_data <= '0;
      ins_pc   <= RESET_VEC;
    end else if (redirect) begin
      // A redirect discards any ack in this cycle and any held instruction.
`ifdef INS_FETCH_ALIGN_CHK_EN
      if (misaligned) begin
        state <= S_FAULT;
      end else begin
        pc    <= reg_pc_w_val;
        state <= S_REQ;
      end
`else
      pc    <= reg_pc_w_val;
      state <= S_REQ;
`endif
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (mem_ack) begin
            ins_data <= mem_rdata;
            ins_pc   <= pc;
            state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (ins_ready) begin
            pc    <= ins_pc + PC_STEP;
            state <= S_REQ;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_pc.sv
module tb_ins_fetch_pc;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_pc_w_op = 1'b0;
  logic [31:0] reg_pc_w_val = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  ins_fetch_pc #(.RESET_VEC(RV), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] val;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[27];

  function automatic vec_t mk(logic op, logic [31:0] val, logic ack, logic [31:0] rdata,
                              logic ready, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_data, logic [31:0] e_pc);
    vec_t v;
    v.op = op; v.val = val; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_data = e_data; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] data,
                            input logic [31:0] pc, input logic fault);
    chk({tag, ".mem_req"},     {31'd0, mem_req},     {31'd0, req});
    chk({tag, ".mem_addr"},    mem_addr,             addr);
    chk({tag, ".ins_valid"},   {31'd0, ins_valid},   {31'd0, valid});
    chk({tag, ".ins_data"},    ins_data,             data);
    chk({tag, ".ins_pc"},      ins_pc,               pc);
    chk({tag, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, fault});
  endtask

  task automatic clear_inputs();
    reg_pc_w_op = 1'b0; reg_pc_w_val = '0;
    mem_ack = 1'b0; mem_rdata = '0; ins_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, RV, 1'b0, 32'h0, RV, 1'b0);
    rst_n = 1'b1;
  endtask

  // Reference model: PC, a one-deep queue of fetched-but-unconsumed
  // instructions, and the most recently captured instruction.
  typedef struct { logic [31:0] data; logic [31:0] pc; } ins_t;
  bit          m_boot;
  bit          m_fault;
  logic [31:0] m_pc;
  ins_t        m_q[$];
  logic [31:0] m_data, m_ipc;

  task automatic model_reset();
    m_boot = 1; m_fault = 0; m_pc = RV; m_q.delete(); m_data = '0; m_ipc = RV;
  endtask

  task automatic model_edge();
    ins_t t;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (reg_pc_w_op) begin
`ifdef INS_FETCH_ALIGN_CHK_EN
      if (reg_pc_w_val % 4 != 0) m_fault = 1;
      else begin m_pc = reg_pc_w_val; m_q.delete(); end
`else
      m_pc = reg_pc_w_val;
      m_q.delete();
`endif
    end else if (m_q.size() == 0) begin
      if (mem_ack) begin
        t.data = mem_rdata; t.pc = m_pc;
        m_q.push_back(t);
        m_data = mem_rdata; m_ipc = m_pc;
      end
    end else if (ins_ready) begin
      m_pc = m_q[0].pc + 32'd4;
      m_q.delete();
    end
  endtask

  initial begin
    vt[0]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h100,      0, 32'h0,        32'h100);
    vt[1]  = mk(0, 32'h0,        1, 32'hAAAA0001, 0, 1, 32'h100,      0, 32'h0,        32'h100);
    vt[2]  = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h100,      1, 32'hAAAA0001, 32'h100);
    vt[3]  = mk(0, 32'h0,        1, 32'hAAAA0002, 0, 1, 32'h104,      0, 32'hAAAA0001, 32'h100);
    vt[4]  = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h104,      1, 32'hAAAA0002, 32'h104);
    vt[5]  = mk(0, 32'h0,        1, 32'hAAAA0003, 0, 1, 32'h108,      0, 32'hAAAA0002, 32'h104);
    vt[6]  = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h108,      1, 32'hAAAA0003, 32'h108);
    vt[7]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h10C,      0, 32'hAAAA0003, 32'h108);
    vt[8]  = vt[7];
    vt[9]  = vt[7];
    vt[10] = mk(0, 32'h0,        1, 32'hAAAA0004, 0, 1, 32'h10C,      0, 32'hAAAA0003, 32'h108);
    vt[11] = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h10C,      1, 32'hAAAA0004, 32'h10C);
    vt[12] = vt[11];
    vt[13] = vt[11];
    vt[14] = vt[11];
    vt[15] = vt[11];
    vt[16] = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h10C,      1, 32'hAAAA0004, 32'h10C);
    vt[17] = mk(1, 32'h200,      0, 32'h0,        0, 1, 32'h110,      0, 32'hAAAA0004, 32'h10C);
    vt[18] = mk(0, 32'h0,        1, 32'hAAAA0005, 0, 1, 32'h200,      0, 32'hAAAA0004, 32'h10C);
    vt[19] = mk(1, 32'h40,       0, 32'h0,        1, 0, 32'h200,      1, 32'hAAAA0005, 32'h200);
    vt[20] = mk(1, 32'h80,       1, 32'hAAAA0006, 0, 1, 32'h40,       0, 32'hAAAA0005, 32'h200);
    vt[21] = mk(1, 32'hFFFFFFFC, 0, 32'h0,        0, 1, 32'h80,       0, 32'hAAAA0005, 32'h200);
    vt[22] = mk(0, 32'h0,        1, 32'hAAAA0007, 0, 1, 32'hFFFFFFFC, 0, 32'hAAAA0005, 32'h200);
    vt[23] = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'hFFFFFFFC, 1, 32'hAAAA0007, 32'hFFFFFFFC);
    vt[24] = mk(0, 32'h0,        1, 32'hAAAA0008, 0, 1, 32'h0,        0, 32'hAAAA0007, 32'hFFFFFFFC);
    vt[25] = mk(1, 32'h300,      0, 32'h0,        0, 0, 32'h0,        1, 32'hAAAA0008, 32'h0);
    vt[26] = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h300,      0, 32'hAAAA0008, 32'h0);

    // Directed table: sequential fetch, slow ack, stall, redirects, wrap.
    #2;
    do_reset();
    for (int i = 0; i < 27; i++) begin
      reg_pc_w_op = vt[i].op; reg_pc_w_val = vt[i].val;
      mem_ack = vt[i].ack; mem_rdata = vt[i].rdata; ins_ready = vt[i].ready;
      check_outs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
                 vt[i].e_data, vt[i].e_pc, 1'b0);
      step();
    end

    // Misaligned redirect target 0x42 from S_REQ (with a same-cycle ack).
    clear_inputs();
    reg_pc_w_op = 1'b1; reg_pc_w_val = 32'h42; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    clear_inputs();
`ifdef INS_FETCH_ALIGN_CHK_EN
    check_outs("misalign", 1'b0, 32'h300, 1'b0, 32'hAAAA0008, 32'h0, 1'b1);
    mem_ack = 1'b1; ins_ready = 1'b1;
    reg_pc_w_op = 1'b1; reg_pc_w_val = 32'h500;
    step(); step(); step();
    check_outs("fault_hold", 1'b0, 32'h300, 1'b0, 32'hAAAA0008, 32'h0, 1'b1);
`else
    check_outs("misalign", 1'b1, 32'h42, 1'b0, 32'hAAAA0008, 32'h0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA0009;
    step();
    clear_inputs();
    check_outs("misalign_fetch", 1'b0, 32'h42, 1'b1, 32'hAAAA0009, 32'h42, 1'b0);
`endif

    // Reset asserted mid-wait: outputs drop without a clock edge.
    do_reset();
    step();
    step();
    check_outs("wait", 1'b1, RV, 1'b0, 32'h0, RV, 1'b0);
    #3;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, RV, 1'b0, 32'h0, RV, 1'b0);
    step();
    check_outs("rst_ack_ignored", 1'b0, RV, 1'b0, 32'h0, RV, 1'b0);
    clear_inputs();
    rst_n = 1'b1;
    step();
    check_outs("boot_exit", 1'b1, RV, 1'b0, 32'h0, RV, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      check_outs("rand", (!m_boot && !m_fault && m_q.size() == 0), m_pc,
                 (m_q.size() != 0), m_data, m_ipc, m_fault);
      reg_pc_w_op  = ($urandom_range(0, 7) == 0);
`ifdef INS_FETCH_ALIGN_CHK_EN
      reg_pc_w_val = $urandom & 32'hFFFF_FFFC;
`else
      reg_pc_w_val = $urandom;
`endif
      mem_ack   = $urandom_range(0, 2) != 0;
      mem_rdata = $urandom;
      ins_ready = $urandom_range(0, 1) == 1;
      model_edge();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
